// File: rtl/rom_fetch_pkg.sv
// Shared types and sizing helpers for the ROM fetch controller.
package rom_fetch_pkg;

  // Controller phases: waiting for a request, issuing addresses, waiting for the tail to drain.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int CREDIT_WIDTH   = $clog2(DEF_FIFO_DEPTH + 1);

  // One buffered return word; packed so it maps directly onto the buffer storage.
  typedef struct packed {
    logic                      err;
    logic                      last;
    logic [DEF_DATA_WIDTH-1:0] data;
  } fetch_entry_t;

  // Credit counter must be able to hold the value FIFO_DEPTH itself.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rom_fetch_fifo.sv
// Synchronous FIFO with a registered head word (first-word fall-through).
// The head register holds the oldest entry; the array holds the rest, so the
// total capacity is DEPTH. full/empty exist only for checking upstream credit logic.
module rom_fetch_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             full,
  output logic             empty
);

  localparam int MEM_DEPTH = DEPTH - 1;
  localparam int PW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNTW      = $clog2(MEM_DEPTH + 1);

  logic [WIDTH-1:0] mem [MEM_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  mem_cnt_q, mem_cnt_d;
  logic             head_valid_q, head_valid_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             mem_wr, mem_rd, pop, head_free;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MEM_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Decide where a push lands and whether the head refills from storage.
  always_comb begin
    pop          = head_valid_q & pop_ready;
    head_free    = ~head_valid_q | pop;
    head_d       = head_q;
    head_valid_d = head_valid_q;
    mem_wr       = 1'b0;
    mem_rd       = 1'b0;
    if (head_free) begin
      if (mem_cnt_q != '0) begin
        mem_rd       = 1'b1;
        head_d       = mem[rd_ptr_q];
        head_valid_d = 1'b1;
        mem_wr       = push;
      end else if (push) begin
        head_d       = push_data;
        head_valid_d = 1'b1;
      end else begin
        head_valid_d = 1'b0;
      end
    end else begin
      mem_wr = push;
    end
    wr_ptr_d  = mem_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = mem_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    mem_cnt_d = mem_cnt_q + CNTW'(mem_wr) - CNTW'(mem_rd);
  end

  // Storage array write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr_q] <= push_data;
  end

  // Pointer, count and head registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_cnt_q    <= '0;
      head_valid_q <= 1'b0;
      head_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_cnt_q    <= mem_cnt_d;
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
    end
  end

  assign out_valid = head_valid_q;
  assign out_data  = head_q;
  assign full      = head_valid_q & (mem_cnt_q == CNTW'(MEM_DEPTH));
  assign empty     = ~head_valid_q;

endmodule

// File: rtl/rom_fetch_ctrl.sv
// ROM burst fetch controller: issues sequential ROM addresses, tags returns
// through a ROM_LATENCY-deep pipeline and buffers them behind a credit counter
// so a stalled consumer can never overflow the buffer.
// Optional build macro ROM_FETCH_ERR_ABORT_EN: the first errored return ends
// the burst (forced last), issuing stops and later in-flight returns are dropped.
module rom_fetch_ctrl
  import rom_fetch_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int LEN_WIDTH   = 8,
  parameter int ROM_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  rom_error,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_err,
  output logic                  busy,
  output logic                  done,
  output logic                  err_sticky
);

  localparam int CW = credit_width(FIFO_DEPTH);
  localparam int EW = DATA_WIDTH + 2;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d, rom_addr_q, rom_addr_d;
  logic [LEN_WIDTH-1:0]    remain_q, remain_d;
  logic [CW-1:0]           credits_q, credits_d, flush_cnt;
  logic                    rom_en_q, rom_en_d, rom_last_q, rom_last_d;
  logic [ROM_LATENCY-1:0]  tag_valid_q, tag_valid_d, tag_last_q, tag_last_d;
  logic                    done_q, done_d, err_sticky_q, err_sticky_d;
  logic                    req_fire, issue, pop, cap_valid, cap_last, abort;
  logic [EW-1:0]           push_entry, head_entry;
  logic                    fifo_valid, fifo_full, fifo_empty;

  assign cap_valid = tag_valid_q[ROM_LATENCY-1];
  assign cap_last  = tag_last_q[ROM_LATENCY-1];

`ifdef ROM_FETCH_ERR_ABORT_EN
  assign abort = cap_valid & rom_error;
`else
  assign abort = 1'b0;
`endif

  // Returned word as stored in the buffer: {err, last, data}.
  assign push_entry = {rom_error, cap_last | abort, rom_data};

  // Tag pipeline input side: stage 0 follows the registered rom_en; an abort drops every in-flight tag.
  genvar gi;
  generate
    for (gi = 0; gi < ROM_LATENCY; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        assign tag_valid_d[gi] = rom_en_q & ~abort;
        assign tag_last_d[gi]  = rom_last_q;
      end else begin : g_body
        assign tag_valid_d[gi] = tag_valid_q[gi-1] & ~abort;
        assign tag_last_d[gi]  = tag_last_q[gi-1];
      end
    end
  endgenerate

  // FSM next state, address issue and completion pulse.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    rom_en_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    rom_last_d = 1'b0;
    done_d     = 1'b0;
    issue      = 1'b0;
    req_ready  = (state_q == IDLE) && !rst;
    req_fire   = req_valid && req_ready;
    unique case (state_q)
      IDLE: begin
        if (req_fire) begin
          if (req_len == '0) begin
            done_d = 1'b1;
          end else begin
            // Buffer is empty in IDLE, so the first word can issue without a credit check.
            issue      = 1'b1;
            rom_en_d   = 1'b1;
            rom_addr_d = req_addr;
            addr_d     = req_addr + ADDR_WIDTH'(1);
            remain_d   = req_len - LEN_WIDTH'(1);
            rom_last_d = (req_len == LEN_WIDTH'(1));
            state_d    = (req_len == LEN_WIDTH'(1)) ? DRAIN : ISSUE;
          end
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d = DRAIN;
        end else if (credits_q != '0) begin
          issue      = 1'b1;
          rom_en_d   = 1'b1;
          rom_addr_d = addr_q;
          addr_d     = addr_q + ADDR_WIDTH'(1);
          remain_d   = remain_q - LEN_WIDTH'(1);
          rom_last_d = (remain_q == LEN_WIDTH'(1));
          if (remain_q == LEN_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_entry[DATA_WIDTH]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit accounting: issue takes one, pop returns one, abort returns those of dropped tags.
  always_comb begin
    flush_cnt = '0;
    if (abort) begin
      flush_cnt = CW'(rom_en_q);
      for (int i = 0; i < ROM_LATENCY - 1; i++) begin
        flush_cnt = flush_cnt + CW'(tag_valid_q[i]);
      end
    end
    credits_d    = credits_q - CW'(issue) + CW'(pop) + flush_cnt;
    err_sticky_d = err_sticky_q | (cap_valid & rom_error);
  end

  // State, issue and tag registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      remain_q     <= '0;
      credits_q    <= CW'(FIFO_DEPTH);
      rom_en_q     <= 1'b0;
      rom_addr_q   <= '0;
      rom_last_q   <= 1'b0;
      tag_valid_q  <= '0;
      tag_last_q   <= '0;
      done_q       <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remain_q     <= remain_d;
      credits_q    <= credits_d;
      rom_en_q     <= rom_en_d;
      rom_addr_q   <= rom_addr_d;
      rom_last_q   <= rom_last_d;
      tag_valid_q  <= tag_valid_d;
      tag_last_q   <= tag_last_d;
      done_q       <= done_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  rom_fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cap_valid & ~rst),
    .push_data (push_entry),
    .pop_ready (out_ready),
    .out_valid (fifo_valid),
    .out_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign pop = fifo_valid & out_ready;

  // Credit scheme must keep the buffer from overflowing, and IDLE implies nothing is left buffered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(cap_valid && fifo_full && !pop));
      assert (!(state_q == IDLE && !fifo_empty));
    end
  end

  assign rom_en     = rom_en_q;
  assign rom_addr   = rom_addr_q;
  assign out_valid  = fifo_valid;
  assign out_data   = head_entry[DATA_WIDTH-1:0];
  assign out_last   = fifo_valid & head_entry[DATA_WIDTH];
  assign out_err    = fifo_valid & head_entry[DATA_WIDTH+1];
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Directed bench for rom_fetch_ctrl with a scoreboard of expected output words.
module tb_rom_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [7:0]  req_addr, req_len;
  logic        rom_en;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        rom_error;
  logic        out_valid, out_ready, out_last, out_err;
  logic [15:0] out_data;
  logic        busy, done, err_sticky;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int words_seen = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_pop_cyc = 0;

  rom_fetch_pkg::fetch_entry_t exp_q[$];
  rom_fetch_pkg::fetch_entry_t mon_e;
  logic [7:0] addr_log[$];

  // ROM model: one-cycle latency, data = addr ^ 0xA500, error on a chosen address
  logic       err_en, rd_en_q;
  logic [7:0] err_addr, rd_addr_q;

  rom_fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data), .rom_error(rom_error),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_err(out_err),
    .busy(busy), .done(done), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    rd_en_q   <= rom_en;
    rd_addr_q <= rom_addr;
  end

  assign rom_data  = {8'h00, rd_addr_q} ^ 16'hA500;
  assign rom_error = rd_en_q && err_en && (rd_addr_q == err_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each accepted word, logs issued addresses and done pulses
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      words_seen++;
      chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("word_data", 32'(out_data), 32'(mon_e.data));
        chk("word_last", 32'(out_last), 32'(mon_e.last));
        chk("word_err",  32'(out_err),  32'(mon_e.err));
      end
      if (out_last) last_pop_cyc = cyc;
    end
    if (!rst && rom_en) begin
      en_cnt++;
      addr_log.push_back(rom_addr);
    end
    if (!rst && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic send_req(input logic [7:0] a, input logic [7:0] n);
    rom_fetch_pkg::fetch_entry_t e;
    int k;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_len = n;
    k = 0;
    while (!req_ready && k < 50) begin @(posedge clk); #1; k++; end
    chk("req_accept", 32'(req_ready), 32'd1);
    for (int i = 0; i < int'(n); i++) begin
      logic [7:0] ai;
      ai = a + 8'(i);
      e.data = {8'h00, ai} ^ 16'hA500;
      e.err  = err_en && (ai == err_addr);
      e.last = (i == int'(n) - 1);
`ifdef ROM_FETCH_ERR_ABORT_EN
      if (e.err) e.last = 1'b1;
`endif
      exp_q.push_back(e);
`ifdef ROM_FETCH_ERR_ABORT_EN
      if (e.err) break;
`endif
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin @(negedge clk); n++; end
    chk({tag, "_done_seen"}, 32'(done_cnt != start), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ws_snap, en_snap, d_snap, first_cyc, n_err_exp, k;
    logic [7:0] wrap_exp [4];
    wrap_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    // Reset state
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0;
    out_ready = 1'b1; err_en = 1'b0; err_addr = '0;
    @(negedge clk);
    chk("rst_req_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rom_en", 32'(rom_en), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err_sticky", 32'(err_sticky), 32'd0);

    // Basic burst: 0x10, len 4
    send_req(8'h10, 8'd4);
    @(negedge clk);
    chk("basic_rom_en_first", 32'(rom_en), 32'd1);
    chk("basic_rom_addr_first", 32'(rom_addr), 32'h10);
    chk("basic_busy", 32'(busy), 32'd1);
    chk("basic_valid_c1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("basic_valid_c2", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("basic_valid_c3", 32'(out_valid), 32'd1);
    first_cyc = cyc;
    wait_done(40, "basic");
    chk("basic_span", 32'(last_pop_cyc - first_cyc), 32'd3);
    chk("basic_done_lat", 32'(done_cyc - last_pop_cyc), 32'd1);
    chk("basic_sb_empty", 32'(exp_q.size()), 32'd0);

    // Back-pressure: len 8 with the consumer stalled
    @(posedge clk); #1;
    out_ready = 1'b0;
    en_snap = en_cnt; ws_snap = words_seen;
    send_req(8'h20, 8'd8);
    repeat (11) @(negedge clk);
    chk("bp_rom_en_bounded", 32'((en_cnt - en_snap) <= 4), 32'd1);
    chk("bp_head_valid", 32'(out_valid), 32'd1);
    chk("bp_head_data", 32'(out_data), 32'hA520);
    chk("bp_none_popped", 32'(words_seen - ws_snap), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done(80, "bp");
    chk("bp_word_count", 32'(words_seen - ws_snap), 32'd8);
    chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Address wrap
    @(posedge clk); #1;
    addr_log.delete();
    send_req(8'hFE, 8'd4);
    wait_done(40, "wrap");
    chk("wrap_issue_count", 32'(addr_log.size()), 32'd4);
    if (addr_log.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("wrap_addr", 32'(addr_log[i]), 32'(wrap_exp[i]));
    end

    // Error on 3rd word of len 6
    @(posedge clk); #1;
    err_en = 1'b1; err_addr = 8'h32;
    ws_snap = words_seen;
    send_req(8'h30, 8'd6);
    wait_done(60, "err");
`ifdef ROM_FETCH_ERR_ABORT_EN
    n_err_exp = 3;
`else
    n_err_exp = 6;
`endif
    chk("err_word_count", 32'(words_seen - ws_snap), 32'(n_err_exp));
    chk("err_sticky_set", 32'(err_sticky), 32'd1);
    chk("err_sb_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    err_en = 1'b0;

    // Reset after the 2nd word of len 8
    ws_snap = words_seen;
    send_req(8'h40, 8'd8);
    k = 0;
    while (words_seen < ws_snap + 2 && k < 40) begin @(negedge clk); k++; end
    chk("rstmid_two_words", 32'(words_seen - ws_snap), 32'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("rstmid_req_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_rom_en", 32'(rom_en), 32'd0);
    chk("rstmid_rom_addr", 32'(rom_addr), 32'd0);
    chk("rstmid_out_valid", 32'(out_valid), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_err_sticky", 32'(err_sticky), 32'd0);
    repeat (3) @(negedge clk);
    chk("rstmid_stale_ignored", 32'(out_valid), 32'd0);
    ws_snap = words_seen;
    send_req(8'h50, 8'd2);
    wait_done(40, "rstmid_next");
    repeat (3) @(negedge clk);
    chk("rstmid_next_count", 32'(words_seen - ws_snap), 32'd2);

    // Zero length request
    en_snap = en_cnt; d_snap = done_cnt;
    send_req(8'h60, 8'd0);
    @(negedge clk);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("zero_done_single", 32'(done), 32'd0);
    chk("zero_busy_after", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    chk("zero_done_count", 32'(done_cnt - d_snap), 32'd1);
    chk("zero_no_rom_en", 32'(en_cnt - en_snap), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
